// File: rtl/video_pkg.sv
// Shared definitions for the video timing path.
// - lock_state_e: lock-qualifier states (wait for lock, settle, run).
// - DEF_*: default raster timing for the 400x360 @ ~60 Hz mode on a 23.75 MHz pixel clock.
// - h_total / v_total: total line / frame length from the porch and sync widths.
package video_pkg;

  typedef enum logic [1:0] {
    WaitLock,
    Settle,
    Run
  } lock_state_e;

  localparam int unsigned DEF_H_ACTIVE  = 400;
  localparam int unsigned DEF_H_FP      = 40;
  localparam int unsigned DEF_H_SYNC    = 32;
  localparam int unsigned DEF_H_BP      = 128;
  localparam int unsigned DEF_V_ACTIVE  = 360;
  localparam int unsigned DEF_V_FP      = 100;
  localparam int unsigned DEF_V_SYNC    = 4;
  localparam int unsigned DEF_V_BP      = 196;
  localparam int unsigned DEF_LOCK_WAIT = 1024;
  localparam int unsigned DEF_CW        = 10;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the timing generator to the renderer / video output.
// - video_en     : raster running
// - hs, vs, de   : syncs and data enable, active high
// - x, y         : current pixel / line position
// - line_start   : one-cycle pulse at x == 0
// - frame_start  : one-cycle pulse at x == 0 && y == 0
// Modports: master (generator drives), slave (consumer reads).
interface video_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          video_en;
  logic          hs;
  logic          vs;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output video_en, hs, vs, de, x, y, line_start, frame_start
  );

  modport slave (
    input video_en, hs, vs, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/lock_qualifier.sv
// Qualifies the PLL locked indication in the pixel-clock domain.
// Ports:
// - clk        : pixel clock
// - rst        : synchronous, active-high reset
// - pll_locked : raw PLL lock, asynchronous to clk
// - lock_ok    : high when the qualifier is in (or entering on the next edge) the Run state
// pll_locked passes a two-flop synchroniser; the synchronised lock must then be seen for
// LOCK_WAIT consecutive cycles in Settle before Run. Any low on the synchronised lock drops
// straight back to WaitLock and the wait restarts from zero.
module lock_qualifier
  import video_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int unsigned CntW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_WAIT - 1);

  logic            sync1_q;
  logic            lk_s_q;
  lock_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
      state_q <= WaitLock;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pll_locked;
      lk_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and lock counter
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      WaitLock: begin
        if (lk_s_q) state_d = Settle;
      end
      Settle: begin
        if (!lk_s_q) begin
          state_d = WaitLock;
        end else if (cnt_q == CntLast) begin
          state_d = Run;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      Run: begin
        if (!lk_s_q) state_d = WaitLock;
      end
      default: state_d = WaitLock;
    endcase
  end

  // Look-ahead on the next state so the top's registered raster outputs go live, and drop,
  // on the same edge the qualifier enters or leaves Run.
  always_comb begin
    lock_ok = (state_d == Run);
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video raster timing generator in the 23.75 MHz pixel-clock domain.
// Ports:
// - clk        : pixel clock (PLL outclk_0)
// - rst        : synchronous, active-high reset
// - pll_locked : PLL locked, asynchronous to clk
// - vid        : raster timing bundle (video_en, hs, vs, de, x, y, line_start, frame_start)
// Once lock is qualified the raster starts at (0,0); x runs 0..H_TOTAL-1, y steps on each
// x wrap and runs 0..V_TOTAL-1. All outputs are registered from the same next position, so
// every output on a cycle describes the same (x,y). Losing lock zeroes everything on the
// next edge and the raster restarts at (0,0) after re-qualification.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned LOCK_WAIT = DEF_LOCK_WAIT,
  parameter int unsigned CW        = DEF_CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] HLast   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HAct    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VAct    = CW'(V_ACTIVE);
  // Inclusive sync bounds, so a zero back porch cannot overflow CW.
  localparam logic [CW-1:0] HsFirst = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HsLast  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VsFirst = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VsLast  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          lock_ok;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          video_en_q, video_en_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  lock_qualifier #(
    .LOCK_WAIT(LOCK_WAIT)
  ) u_lock_qualifier (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .lock_ok   (lock_ok)
  );

  // Next raster position and its decode
  always_comb begin
    x_d           = '0;
    y_d           = '0;
    video_en_d    = 1'b0;
    hs_d          = 1'b0;
    vs_d          = 1'b0;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (lock_ok) begin
      // First Run cycle starts at (0,0); afterwards advance with wrap.
      if (video_en_q) begin
        if (x_q == HLast) begin
          x_d = '0;
          y_d = (y_q == VLast) ? '0 : y_q + CW'(1);
        end else begin
          x_d = x_q + CW'(1);
          y_d = y_q;
        end
      end
      video_en_d    = 1'b1;
      de_d          = (x_d < HAct) && (y_d < VAct);
      hs_d          = (x_d >= HsFirst) && (x_d <= HsLast);
      vs_d          = (y_d >= VsFirst) && (y_d <= VsLast);
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      video_en_q    <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      video_en_q    <= video_en_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.video_en    = video_en_q;
  assign vid.hs          = hs_q;
  assign vid.vs          = vs_q;
  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a small 8x6 raster and LOCK_WAIT = 4.
// The driver issues rst / pll_locked before each rising edge and pushes the expected outputs
// for that edge; the monitor pops and compares one entry after every rising edge.
// Reference model: outputs are live iff the last LOCK_WAIT+1 pll_locked samples taken two
// edges earlier were all 1 (reset counts as zero samples); the raster position is the
// number of cycles since going live, folded into (x,y).
module tb_video_timing_gen;
  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned LW = 4, CW = 4;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  typedef struct packed {
    logic          video_en;
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;

  video_timing_gen_if #(.CW(CW)) vid ();

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE (VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOCK_WAIT(LW), .CW(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .vid       (vid)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state
  int runlen = 0;   // consecutive locked samples ending at the latest edge
  int hist1  = 0;   // runlen one edge back
  int hist2  = 0;   // runlen two edges back
  int pix    = 0;   // cycles since going live, modulo frame length
  bit prev_en = 1'b0;
  bit cur_en  = 1'b0;
  int cur_x   = 0;
  int cur_y   = 0;

  task automatic model_edge(input logic r, input logic p, output out_t e);
    bit en;
    en = !r && (hist2 >= LW + 1);
    if (r) begin
      runlen = 0;
      hist1  = 0;
      hist2  = 0;
    end else begin
      runlen = p ? ((runlen < 1000) ? runlen + 1 : runlen) : 0;
      hist2  = hist1;
      hist1  = runlen;
    end
    pix     = (en && prev_en) ? (pix + 1) % (HT * VT) : 0;
    prev_en = en;
    cur_en  = en;
    cur_x   = en ? pix % HT : 0;
    cur_y   = en ? pix / HT : 0;
    e = '0;
    if (en) begin
      e.video_en    = 1'b1;
      e.x           = CW'(cur_x);
      e.y           = CW'(cur_y);
      e.de          = (cur_x < HA) && (cur_y < VA);
      e.hs          = (cur_x >= HA + HF) && (cur_x < HA + HF + HS);
      e.vs          = (cur_y >= VA + VF) && (cur_y < VA + VF + VS);
      e.line_start  = (cur_x == 0);
      e.frame_start = (cur_x == 0) && (cur_y == 0);
    end
  endtask

  task automatic step(input logic r, input logic p);
    out_t e;
    @(negedge clk);
    rst        = r;
    pll_locked = p;
    model_edge(r, p, e);
    exp_q.push_back(e);
  endtask

  task automatic run_until(input int tx, input int ty, input string name);
    int i;
    i = 0;
    while (!(cur_en && cur_x == tx && cur_y == ty) && i < 500) begin
      step(1'b0, 1'b1);
      i++;
    end
    if (i >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: raster position (%0d,%0d) not reached within 500 cycles", name, tx, ty);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {vid.video_en, vid.hs, vid.vs, vid.de, vid.x, vid.y, vid.line_start,
             vid.frame_start};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got en=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected en=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                   $time, a.video_en, a.hs, a.vs, a.de, a.x, a.y, a.line_start, a.frame_start,
                   e.video_en, e.hs, e.vs, e.de, e.x, e.y, e.line_start, e.frame_start);
        end
      end
    end
  end

  // Driver
  initial begin
    // Reset with the PLL already locked, then lock-up and two full frames incl. the wrap.
    repeat (3) step(1'b1, 1'b1);
    repeat (LW + 2 + 2 * HT * VT + 5) step(1'b0, 1'b1);

    // Lock loss mid-frame, then re-lock.
    run_until(3, 1, "lock_loss_pos");
    repeat (3) step(1'b0, 1'b0);
    repeat (LW + 2 + 20) step(1'b0, 1'b1);

    // Single-cycle glitch during Settle after two counts.
    repeat (3) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (LW + 2 + 12) step(1'b0, 1'b1);

    // Reset while running, then full lock-up again.
    run_until(6, 4, "rst_in_run_pos");
    step(1'b1, 1'b1);
    repeat (LW + 2 + HT * VT + 4) step(1'b0, 1'b1);

    // Random lock drops and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1);
    end

    repeat (3) step(1'b0, 1'b1);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
